muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32IM M-extension unit (MUL/MULH*/DIV*/REM*).
// Sits in EX beside the ALU; stalls the pipe via busy, pulses done on completion.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, op, rs1, rs2 request (funct3 encoding) and operands
//   dest_addr           destination tag carried to dest_addr_out
//   flush               abort the in-flight operation
//   ready, busy, done   handshake / stall / one-cycle completion pulse
//   result              final value, held until the next completion
//   dest_addr_out       tag of the completed operation
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      dest_addr,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      dest_addr_out
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_SIGN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [4:0]      tag_q;
    logic            prod_neg;
    logic            rem_neg;
    logic [XLEN-1:0] opb_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] lo_q;

    logic accept;

    assign ready  = (state == ST_IDLE) || (state == ST_DONE);
    assign busy   = (state == ST_CALC) || (state == ST_SIGN);
    assign done   = (state == ST_DONE);
    assign accept = start && ready && !flush;

    // ---------------- operand decode at acceptance ----------------
    logic            rs1_signed;
    logic            rs2_signed;
    logic            neg1;
    logic            neg2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            is_div;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        unique case (op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                rs1_signed = 1'b1;
                rs2_signed = 1'b1;
            end
            3'b010: rs1_signed = 1'b1;
            default: ;
        endcase
    end

    assign neg1 = rs1_signed && rs1[XLEN-1];
    assign neg2 = rs2_signed && rs2[XLEN-1];
    assign mag1 = neg1 ? -rs1 : rs1;
    assign mag2 = neg2 ? -rs2 : rs2;

    assign is_div   = op[2];
    assign div_zero = is_div && (rs2 == '0);
    // Only the signed forms (op[0]=0) can overflow.
    assign div_ovf  = is_div && !op[0] && !div_zero
                      && (rs1 == INT_MIN) && (rs2 == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op[1] ? rs1 : '1;
        else
            special_res = op[1] ? '0 : rs1;
    end

    // ---------------- iteration datapath ----------------
    // Multiply: {acc_q, lo_q} is a right-shifting product register with
    // the multiplier in lo_q; MUL_STEP bits are retired per cycle.
    logic [XLEN+MUL_STEP-1:0] mul_sum;
    logic [XLEN+MUL_STEP-1:0] mul_pp;

    assign mul_pp  = {{MUL_STEP{1'b0}}, opb_q}
                   * {{XLEN{1'b0}}, lo_q[MUL_STEP-1:0]};
    assign mul_sum = {{MUL_STEP{1'b0}}, acc_q} + mul_pp;

    // Divide: restoring; acc_q is the partial remainder, lo_q shifts the
    // dividend out at the top while quotient bits enter at the bottom.
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_diff;
    logic          div_ge;

    assign div_shift = {acc_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ge    = !div_diff[XLEN];

    logic [XLEN-1:0] acc_nxt;
    logic [XLEN-1:0] lo_nxt;

    always_comb begin
        acc_nxt = acc_q;
        lo_nxt  = lo_q;
        if (op_q[2]) begin
            acc_nxt = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_nxt  = {lo_q[XLEN-2:0], div_ge};
        end else begin
            acc_nxt = mul_sum[XLEN+MUL_STEP-1:MUL_STEP];
            lo_nxt  = {mul_sum[MUL_STEP-1:0], lo_q[XLEN-1:MUL_STEP]};
        end
    end

    // ---------------- sign correction / result select ----------------
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   remv;
    logic [XLEN-1:0]   final_res;

    assign prod_mag = {acc_q, lo_q};
    assign prod_fix = prod_neg ? -prod_mag : prod_mag;
    assign quot     = prod_neg ? -lo_q : lo_q;
    assign remv     = rem_neg ? -acc_q : acc_q;

    always_comb begin
        final_res = '0;
        if (op_q[2])
            final_res = op_q[1] ? remv : quot;
        else if (op_q[1:0] == 2'b00)
            final_res = prod_fix[XLEN-1:0];
        else
            final_res = prod_fix[2*XLEN-1:XLEN];
    end

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            op_q          <= '0;
            tag_q         <= '0;
            prod_neg      <= 1'b0;
            rem_neg       <= 1'b0;
            opb_q         <= '0;
            acc_q         <= '0;
            lo_q          <= '0;
            result        <= '0;
            dest_addr_out <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        op_q     <= op;
                        tag_q    <= dest_addr;
                        prod_neg <= neg1 ^ neg2;
                        rem_neg  <= neg1;
                        opb_q    <= mag2;
                        acc_q    <= '0;
                        lo_q     <= mag1;
                        if (special) begin
                            state         <= ST_DONE;
                            result        <= special_res;
                            dest_addr_out <= dest_addr;
                        end else begin
                            state <= ST_CALC;
                            cnt   <= is_div ? DIV_LAST : MUL_LAST;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_nxt;
                    lo_q  <= lo_nxt;
                    if (cnt == '0)
                        state <= ST_SIGN;
                    else
                        cnt <= cnt - 1'b1;
                end
                ST_SIGN: begin
                    result        <= final_res;
                    dest_addr_out <= tag_q;
                    state         <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: one XLEN=32/MUL_STEP=1 instance (a)
// and one XLEN=32/MUL_STEP=4 instance (b).
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_start = 1'b0, a_flush = 1'b0;
    logic [2:0]  a_op = '0;
    logic [31:0] a_rs1 = '0, a_rs2 = '0;
    logic [4:0]  a_dest = '0;
    logic        a_ready, a_busy, a_done;
    logic [31:0] a_result;
    logic [4:0]  a_dest_out;

    logic        b_start = 1'b0, b_flush = 1'b0;
    logic [2:0]  b_op = '0;
    logic [31:0] b_rs1 = '0, b_rs2 = '0;
    logic [4:0]  b_dest = '0;
    logic        b_ready, b_busy, b_done;
    logic [31:0] b_result;
    logic [4:0]  b_dest_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .MUL_STEP(1)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .op(a_op),
        .rs1(a_rs1), .rs2(a_rs2), .dest_addr(a_dest), .flush(a_flush),
        .ready(a_ready), .busy(a_busy), .done(a_done),
        .result(a_result), .dest_addr_out(a_dest_out)
    );

    muldiv_unit #(.XLEN(32), .MUL_STEP(4)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .op(b_op),
        .rs1(b_rs1), .rs2(b_rs2), .dest_addr(b_dest), .flush(b_flush),
        .ready(b_ready), .busy(b_busy), .done(b_done),
        .result(b_result), .dest_addr_out(b_dest_out)
    );

    // Issue one op on instance a; lat = cycle (start cycle = 0) with done.
    task automatic run_a(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] t,
                         output logic [31:0] r, output logic [4:0] rt,
                         output int lat, output int bz);
        @(posedge clk); #1;
        a_start = 1'b1; a_op = o; a_rs1 = x; a_rs2 = y; a_dest = t;
        @(posedge clk); #1;
        a_start = 1'b0; a_op = 3'b111;
        a_rs1 = 32'hDEAD_BEEF; a_rs2 = 32'h1234_5678; a_dest = 5'd31;
        lat = 1; bz = 0;
        while (!a_done && lat < 100) begin
            if (a_busy) bz++;
            @(posedge clk); #1;
            lat++;
        end
        r = a_result; rt = a_dest_out;
    endtask

    task automatic run_b(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] t,
                         output logic [31:0] r, output int lat);
        @(posedge clk); #1;
        b_start = 1'b1; b_op = o; b_rs1 = x; b_rs2 = y; b_dest = t;
        @(posedge clk); #1;
        b_start = 1'b0; b_rs1 = 32'hDEAD_BEEF; b_rs2 = 32'h1234_5678;
        lat = 1;
        while (!b_done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = b_result;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_ready !== 1'b1) begin bad++;
            $display("FAIL rst_ready got=%b want=1", a_ready); end
        total++; if (a_busy !== 1'b0) begin bad++;
            $display("FAIL rst_busy got=%b want=0", a_busy); end
        total++; if (a_done !== 1'b0) begin bad++;
            $display("FAIL rst_done got=%b want=0", a_done); end
        total++; if (a_result !== 32'h0) begin bad++;
            $display("FAIL rst_result got=%h want=0", a_result); end
        total++; if (a_dest_out !== 5'd0) begin bad++;
            $display("FAIL rst_dest got=%0d want=0", a_dest_out); end
        total++; if ({b_ready, b_busy, b_done} !== 3'b100) begin bad++;
            $display("FAIL rst_b_ctl got=%b want=100",
                     {b_ready, b_busy, b_done}); end
        rst = 1'b0;
    endtask

    task automatic test_mul;
        logic [31:0] r; logic [4:0] t; int lat, bz;
        run_a(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, r, t, lat, bz);
        total++; if (r !== 32'hFFFF_FFEB) begin bad++;
            $display("FAIL mul_result got=%h want=ffffffeb", r); end
        total++; if (t !== 5'd5) begin bad++;
            $display("FAIL mul_dest got=%0d want=5", t); end
        total++; if (lat != 34) begin bad++;
            $display("FAIL mul_latency got=%0d want=34", lat); end
        total++; if (bz != 33) begin bad++;
            $display("FAIL mul_busy_cycles got=%0d want=33", bz); end
    endtask

    task automatic test_mulh;
        logic [31:0] r; logic [4:0] t; int lat, bz;
        run_a(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, r, t, lat, bz);
        total++; if (r !== 32'h4000_0000) begin bad++;
            $display("FAIL mulh got=%h want=40000000", r); end
        run_a(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, r, t, lat, bz);
        total++; if (r !== 32'hFFFF_FFFE) begin bad++;
            $display("FAIL mulhu got=%h want=fffffffe", r); end
        total++; if (lat != 34) begin bad++;
            $display("FAIL mulhu_latency got=%0d want=34", lat); end
        run_a(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, r, t, lat, bz);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++;
            $display("FAIL mulhsu got=%h want=ffffffff", r); end
        total++; if (t !== 5'd3) begin bad++;
            $display("FAIL mulhsu_dest got=%0d want=3", t); end
    endtask

    task automatic test_div;
        logic [31:0] r; logic [4:0] t; int lat, bz;
        run_a(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, r, t, lat, bz);
        total++; if (r !== 32'hFFFF_FFFD) begin bad++;
            $display("FAIL div got=%h want=fffffffd", r); end
        total++; if (lat != 34) begin bad++;
            $display("FAIL div_latency got=%0d want=34", lat); end
        run_a(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4, r, t, lat, bz);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++;
            $display("FAIL rem got=%h want=ffffffff", r); end
        run_a(3'b101, 32'd100, 32'd7, 5'd6, r, t, lat, bz);
        total++; if (r !== 32'd14) begin bad++;
            $display("FAIL divu got=%h want=0000000e", r); end
        run_a(3'b111, 32'd100, 32'd7, 5'd6, r, t, lat, bz);
        total++; if (r !== 32'd2) begin bad++;
            $display("FAIL remu got=%h want=00000002", r); end
        total++; if (lat != 34) begin bad++;
            $display("FAIL remu_latency got=%0d want=34", lat); end
        // Unsigned divide by all-ones is an ordinary operation.
        run_a(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, r, t, lat, bz);
        total++; if (r !== 32'd0) begin bad++;
            $display("FAIL divu_max got=%h want=0", r); end
        total++; if (lat != 34) begin bad++;
            $display("FAIL divu_max_latency got=%0d want=34", lat); end
    endtask

    task automatic test_special;
        logic [31:0] r; logic [4:0] t; int lat, bz;
        run_a(3'b100, 32'd5, 32'd0, 5'd10, r, t, lat, bz);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++;
            $display("FAIL div0 got=%h want=ffffffff", r); end
        total++; if (lat != 1) begin bad++;
            $display("FAIL div0_latency got=%0d want=1", lat); end
        total++; if (t !== 5'd10) begin bad++;
            $display("FAIL div0_dest got=%0d want=10", t); end
        run_a(3'b110, 32'd5, 32'd0, 5'd11, r, t, lat, bz);
        total++; if (r !== 32'd5) begin bad++;
            $display("FAIL rem0 got=%h want=00000005", r); end
        run_a(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, r, t, lat, bz);
        total++; if (r !== 32'h8000_0000) begin bad++;
            $display("FAIL div_ovf got=%h want=80000000", r); end
        total++; if (lat != 1) begin bad++;
            $display("FAIL div_ovf_latency got=%0d want=1", lat); end
        run_a(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, r, t, lat, bz);
        total++; if (r !== 32'd0) begin bad++;
            $display("FAIL rem_ovf got=%h want=0", r); end
        run_a(3'b111, 32'hFFFF_FFF0, 32'd0, 5'd14, r, t, lat, bz);
        total++; if (r !== 32'hFFFF_FFF0) begin bad++;
            $display("FAIL remu0 got=%h want=fffffff0", r); end
    endtask

    task automatic test_flush;
        logic [31:0] prev; int cyc, dn;
        @(posedge clk); #1;
        prev = a_result;
        a_start = 1'b1; a_op = 3'b100; a_rs1 = 32'd1000; a_rs2 = 32'd3;
        a_dest = 5'd7;
        @(posedge clk); #1;
        a_start = 1'b0;
        dn = 0;
        for (cyc = 1; cyc <= 10; cyc++) begin
            if (a_done) dn++;
            if (cyc == 5) begin
                a_start = 1'b1; a_op = 3'b000; a_rs1 = 32'd9; a_rs2 = 32'd9;
                a_dest = 5'd9;
            end
            if (cyc == 6) a_start = 1'b0;
            if (cyc == 10) a_flush = 1'b1;
            @(posedge clk); #1;
        end
        a_flush = 1'b0;
        total++; if (a_busy !== 1'b0) begin bad++;
            $display("FAIL flush_busy got=%b want=0", a_busy); end
        total++; if (a_ready !== 1'b1) begin bad++;
            $display("FAIL flush_ready got=%b want=1", a_ready); end
        total++; if (a_done !== 1'b0 || dn != 0) begin bad++;
            $display("FAIL flush_done got=%b/%0d want=0/0", a_done, dn); end
        total++; if (a_result !== prev) begin bad++;
            $display("FAIL flush_result got=%h want=%h", a_result, prev); end
        a_start = 1'b1; a_op = 3'b000; a_rs1 = 32'd3; a_rs2 = 32'd4;
        a_dest = 5'd3;
        @(posedge clk); #1;
        a_start = 1'b0;
        cyc = 12;
        while (!a_done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++; if (cyc != 45) begin bad++;
            $display("FAIL flush_restart_cycle got=%0d want=45", cyc); end
        total++; if (a_result !== 32'd12) begin bad++;
            $display("FAIL flush_restart_result got=%h want=c", a_result); end
        total++; if (a_dest_out !== 5'd3) begin bad++;
            $display("FAIL flush_restart_dest got=%0d want=3", a_dest_out); end
    endtask

    task automatic test_rst_mid;
        int dn;
        @(posedge clk); #1;
        a_start = 1'b1; a_op = 3'b000; a_rs1 = 32'd5; a_rs2 = 32'd5;
        a_dest = 5'd20;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if ({a_ready, a_busy} !== 2'b10) begin bad++;
            $display("FAIL rst_mid_ctl got=%b want=10", {a_ready, a_busy}); end
        total++; if (a_result !== 32'd0 || a_dest_out !== 5'd0) begin bad++;
            $display("FAIL rst_mid_out got=%h/%0d want=0/0",
                     a_result, a_dest_out); end
        dn = 0;
        repeat (40) begin
            if (a_done) dn++;
            @(posedge clk); #1;
        end
        total++; if (dn != 0) begin bad++;
            $display("FAIL rst_mid_no_done got=%0d want=0", dn); end
    endtask

    task automatic test_step4;
        logic [31:0] r; int lat;
        run_b(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, r, lat);
        total++; if (r !== 32'hFFFF_FFFE) begin bad++;
            $display("FAIL s4_mulhu got=%h want=fffffffe", r); end
        total++; if (lat != 10) begin bad++;
            $display("FAIL s4_mulhu_latency got=%0d want=10", lat); end
        run_b(3'b001, 32'h8000_0000, 32'd3, 5'd5, r, lat);
        total++; if (r !== 32'hFFFF_FFFE) begin bad++;
            $display("FAIL s4_mulh got=%h want=fffffffe", r); end
        run_b(3'b101, 32'd100, 32'd7, 5'd6, r, lat);
        total++; if (r !== 32'd14) begin bad++;
            $display("FAIL s4_divu got=%h want=e", r); end
        total++; if (lat != 34) begin bad++;
            $display("FAIL s4_divu_latency got=%0d want=34", lat); end
    endtask

    task automatic test_back_to_back;
        int cyc, d1, d2;
        logic [31:0] r1, r2;
        logic [4:0] t1, t2;
        r1 = '0; r2 = '0; t1 = '0; t2 = '0;
        @(posedge clk); #1;
        b_start = 1'b1; b_op = 3'b000; b_rs1 = 32'd6; b_rs2 = 32'd7;
        b_dest = 5'd1;
        @(posedge clk); #1;
        b_start = 1'b0;
        cyc = 1; d1 = -1; d2 = -1;
        while (cyc < 60 && d2 < 0) begin
            if (cyc == 5) begin
                b_start = 1'b1; b_rs1 = 32'd2; b_rs2 = 32'd3; b_dest = 5'd2;
            end
            if (b_done) begin
                if (d1 < 0) begin
                    d1 = cyc; r1 = b_result; t1 = b_dest_out;
                end else begin
                    d2 = cyc; r2 = b_result; t2 = b_dest_out;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (d1 >= 0 && cyc == d1 + 1) b_start = 1'b0;
        end
        b_start = 1'b0;
        total++; if (d1 != 10) begin bad++;
            $display("FAIL b2b_first_cycle got=%0d want=10", d1); end
        total++; if (r1 !== 32'd42 || t1 !== 5'd1) begin bad++;
            $display("FAIL b2b_first got=%h/%0d want=2a/1", r1, t1); end
        total++; if (d2 != 20) begin bad++;
            $display("FAIL b2b_second_cycle got=%0d want=20", d2); end
        total++; if (r2 !== 32'd6 || t2 !== 5'd2) begin bad++;
            $display("FAIL b2b_second got=%h/%0d want=6/2", r2, t2); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_step4();
        test_back_to_back();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
